// File: rtl/rf_wb_pkg.sv
// Shared types for the register-file write-back controller: entry layout,
// write-port source selection and default geometry.
package rf_wb_pkg;

   localparam int WB_A_WIDTH  = 5;
   localparam int WB_D_WIDTH  = 32;
   localparam int WB_LQ_DEPTH = 4;
   localparam int REG_COUNT   = 2 ** WB_A_WIDTH;

   typedef struct packed {
      logic [WB_A_WIDTH-1:0] rd;
      logic [WB_D_WIDTH-1:0] data;
   } wb_entry_t;

   typedef enum logic [1:0] {
      SEL_IDLE = 2'd0,
      SEL_ALU  = 2'd1,
      SEL_LQ   = 2'd2
   } wb_sel_t;

endpackage

// File: rtl/rf_wb_ctrl_fifo.sv
// Generic synchronous circular FIFO with occupancy count; the caller never
// pushes when full nor pops when empty.
module wb_fifo #(
   parameter int WIDTH = 37,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       push_data_i,
   input  logic                   pop_i,
   output logic [WIDTH-1:0]       pop_data_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
   localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
   localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wptr_q;
   logic [PW-1:0]    rptr_q;
   logic [PW:0]      count_q;
   logic [PW:0]      count_d;

   // Occupancy next state
   always_comb begin
      count_d = count_q;
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // Pointers and count; DEPTH is a power of two so pointers wrap naturally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= {PW{1'b0}};
         rptr_q  <= {PW{1'b0}};
         count_q <= {(PW+1){1'b0}};
      end else begin
         if (push_i) wptr_q <= wptr_q + PTR_ONE;
         if (pop_i)  rptr_q <= rptr_q + PTR_ONE;
         count_q <= count_d;
      end
   end

   // Storage array
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wptr_q] <= push_data_i;
   end

   assign pop_data_o = mem_q[rptr_q];
   assign full_o     = (count_q == CNT_FULL);
   assign empty_o    = (count_q == {(PW+1){1'b0}});
   assign count_o    = count_q;

endmodule

// File: rtl/rf_wb_ctrl.sv
// Register-file write-port controller: merges ALU results with queued load
// returns and tracks per-register outstanding loads for decode interlock.
module rf_wb_ctrl
   import rf_wb_pkg::*;
#(
   parameter int A_WIDTH  = WB_A_WIDTH,
   parameter int D_WIDTH  = WB_D_WIDTH,
   parameter int LQ_DEPTH = WB_LQ_DEPTH
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      alu_valid,
   input  logic [A_WIDTH-1:0]        alu_rd,
   input  logic [D_WIDTH-1:0]        alu_data,
   output logic                      alu_stall,
   input  logic                      ld_issue,
   input  logic [A_WIDTH-1:0]        ld_issue_rd,
   input  logic                      ld_valid,
   input  logic [A_WIDTH-1:0]        ld_rd,
   input  logic [D_WIDTH-1:0]        ld_data,
   output logic                      ld_ready,
   input  logic [A_WIDTH-1:0]        chk_ad1,
   input  logic [A_WIDTH-1:0]        chk_ad2,
   output logic                      busy1,
   output logic                      busy2,
   output logic                      we3,
   output logic [A_WIDTH-1:0]        ad3,
   output logic [D_WIDTH-1:0]        wd3,
   output logic [$clog2(LQ_DEPTH):0] lq_count
);

   localparam int EW   = A_WIDTH + D_WIDTH;
   localparam int NREG = 2 ** A_WIDTH;
   localparam logic [A_WIDTH-1:0] RD_ZERO = {A_WIDTH{1'b0}};

   logic               lq_full_s;
   logic               lq_empty_s;
   logic               lq_push_s;
   logic               lq_pop_s;
   logic [EW-1:0]      lq_head_s;
   logic [A_WIDTH-1:0] head_rd_s;
   logic [D_WIDTH-1:0] head_data_s;
   wb_sel_t            sel_s;
   logic [A_WIDTH-1:0] sel_rd_s;
   logic [D_WIDTH-1:0] sel_data_s;
   logic               we3_q;
   logic [A_WIDTH-1:0] ad3_q;
   logic [D_WIDTH-1:0] wd3_q;
   logic [NREG-1:0]    pending_q;
   logic [NREG-1:0]    pending_d;

   assign lq_push_s   = ld_valid && !lq_full_s;
   assign head_rd_s   = lq_head_s[EW-1:D_WIDTH];
   assign head_data_s = lq_head_s[D_WIDTH-1:0];

   wb_fifo #(
      .WIDTH (EW),
      .DEPTH (LQ_DEPTH)
   ) u_lq (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (lq_push_s),
      .push_data_i ({ld_rd, ld_data}),
      .pop_i       (lq_pop_s),
      .pop_data_o  (lq_head_s),
      .full_o      (lq_full_s),
      .empty_o     (lq_empty_s),
      .count_o     (lq_count)
   );

   // Source selection; a full queue drains first so loads cannot deadlock
   always_comb begin
      sel_s      = SEL_IDLE;
      sel_rd_s   = head_rd_s;
      sel_data_s = head_data_s;
      if (lq_full_s && alu_valid) begin
         sel_s = SEL_LQ;
      end else if (alu_valid) begin
         sel_s      = SEL_ALU;
         sel_rd_s   = alu_rd;
         sel_data_s = alu_data;
      end else if (!lq_empty_s) begin
         sel_s = SEL_LQ;
      end else begin
         sel_s = SEL_IDLE;
      end
   end

   assign lq_pop_s  = (sel_s == SEL_LQ);
   assign alu_stall = lq_full_s && alu_valid;
   assign ld_ready  = !lq_full_s;

   // Pending next state: set after clear so a newer outstanding load survives
   always_comb begin
      pending_d = pending_q;
      if (lq_pop_s) begin
         pending_d[head_rd_s] = 1'b0;
      end else begin
         pending_d = pending_q;
      end
      if (ld_issue && (ld_issue_rd != RD_ZERO)) begin
         pending_d[ld_issue_rd] = 1'b1;
      end else begin
         pending_d = pending_d;
      end
      pending_d[0] = 1'b0;
   end

   // Registered write port and scoreboard
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we3_q     <= 1'b0;
         ad3_q     <= {A_WIDTH{1'b0}};
         wd3_q     <= {D_WIDTH{1'b0}};
         pending_q <= {NREG{1'b0}};
      end else begin
         pending_q <= pending_d;
         case (sel_s)
            SEL_ALU, SEL_LQ: begin
               if (sel_rd_s != RD_ZERO) begin
                  we3_q <= 1'b1;
                  ad3_q <= sel_rd_s;
                  wd3_q <= sel_data_s;
               end else begin
                  we3_q <= 1'b0;
               end
            end
            default: we3_q <= 1'b0;
         endcase
      end
   end

   assign we3 = we3_q;
   assign ad3 = ad3_q;
   assign wd3 = wd3_q;

   // The write registered this edge reaches the register file one edge later
   always_comb begin
      busy1 = (chk_ad1 != RD_ZERO) && (pending_q[chk_ad1] || (we3_q && (ad3_q == chk_ad1)));
      busy2 = (chk_ad2 != RD_ZERO) && (pending_q[chk_ad2] || (we3_q && (ad3_q == chk_ad2)));
   end

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Scoreboard bench for rf_wb_ctrl: directed stimulus queues expected writes,
// a monitor compares every register-file write against them.
module tb_rf_wb_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        alu_stall;
   logic        ld_issue;
   logic [4:0]  ld_issue_rd;
   logic        ld_valid;
   logic [4:0]  ld_rd;
   logic [31:0] ld_data;
   logic        ld_ready;
   logic [4:0]  chk_ad1;
   logic [4:0]  chk_ad2;
   logic        busy1;
   logic        busy2;
   logic        we3;
   logic [4:0]  ad3;
   logic [31:0] wd3;
   logic [2:0]  lq_count;

   int errors = 0;
   int checks = 0;
   logic [36:0] exp_q[$];

   always #5 clk = ~clk;

   rf_wb_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
      .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
      .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
      .chk_ad1(chk_ad1), .chk_ad2(chk_ad2), .busy1(busy1), .busy2(busy2),
      .we3(we3), .ad3(ad3), .wd3(wd3), .lq_count(lq_count)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d);
      exp_q.push_back({rd, d});
   endtask

   // Monitor: every write must match the oldest expected write
   initial begin
      logic [36:0] e;
      forever begin
         @(posedge clk);
         #2;
         if (rst_n && we3) begin
            if (exp_q.size() == 0) begin
               check("unexpected_we3", we3, 1'b0);
            end else begin
               e = exp_q.pop_front();
               check("wr_ad3", ad3, e[36:32]);
               check("wr_wd3", wd3, e[31:0]);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
      ld_issue = 1'b0; ld_issue_rd = 5'd0; ld_valid = 1'b0; ld_rd = 5'd0; ld_data = 32'd0;
      chk_ad1 = 5'd0; chk_ad2 = 5'd0;
      #1;
      check("rst_we3", we3, 1'b0);
      check("rst_ad3", ad3, 5'd0);
      check("rst_wd3", wd3, 32'd0);
      check("rst_count", lq_count, 3'd0);
      check("rst_ld_ready", ld_ready, 1'b1);
      check("rst_alu_stall", alu_stall, 1'b0);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);

      // Single ALU write
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hDEADBEEF; expect_wr(5'd3, 32'hDEADBEEF);
      @(negedge clk); alu_valid = 1'b0; #1;
      check("alu_we3", we3, 1'b1);
      check("alu_ad3", ad3, 5'd3);
      @(negedge clk); #1;
      check("alu_we3_after", we3, 1'b0);

      // Load interlock on r7
      @(negedge clk); ld_issue = 1'b1; ld_issue_rd = 5'd7; chk_ad1 = 5'd7;
      @(negedge clk); ld_issue = 1'b0;
      ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h12345678; expect_wr(5'd7, 32'h12345678);
      #1; check("ld_busy_issued", busy1, 1'b1);
      @(negedge clk); ld_valid = 1'b0; #1;
      check("ld_busy_queued", busy1, 1'b1);
      check("ld_count1", lq_count, 3'd1);
      @(negedge clk); #1;
      check("ld_we3", we3, 1'b1);
      check("ld_ad3", ad3, 5'd7);
      check("ld_busy_inflight", busy1, 1'b1);
      check("ld_count0", lq_count, 3'd0);
      @(negedge clk); #1;
      check("ld_busy_clear", busy1, 1'b0);

      // Fill the queue behind continuous ALU traffic
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         alu_valid = 1'b1; alu_rd = 5'(10 + 2 * i); alu_data = 32'(32'hA0000000 + i);
         ld_valid = 1'b1; ld_rd = 5'(11 + 2 * i); ld_data = 32'(32'hB0000000 + i);
         expect_wr(5'(10 + 2 * i), 32'(32'hA0000000 + i));
         #1; check("fill_count", lq_count, 3'(i));
         check("fill_ld_ready", ld_ready, 1'b1);
      end
      @(negedge clk);
      alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'hA0000004; ld_valid = 1'b0;
      expect_wr(5'd11, 32'hB0000000);
      expect_wr(5'd20, 32'hA0000004);
      for (int i = 1; i < 4; i++) expect_wr(5'(11 + 2 * i), 32'(32'hB0000000 + i));
      #1;
      check("full_count", lq_count, 3'd4);
      check("full_ld_ready", ld_ready, 1'b0);
      check("full_alu_stall", alu_stall, 1'b1);
      @(negedge clk); #1;
      check("drain_alu_stall", alu_stall, 1'b0);
      check("drain_count", lq_count, 3'd3);
      check("drain_ad3", ad3, 5'd11);
      @(negedge clk); alu_valid = 1'b0;
      repeat (4) @(negedge clk);
      #1; check("drain_empty", lq_count, 3'd0);

      // Writes to x0 are dropped, load slot still freed
      @(negedge clk); alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFFFFFF;
      @(negedge clk); alu_valid = 1'b0; #1;
      check("x0_alu_we3", we3, 1'b0);
      ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h00000055;
      @(negedge clk); ld_valid = 1'b0; #1;
      check("x0_ld_count1", lq_count, 3'd1);
      @(negedge clk); #1;
      check("x0_ld_count0", lq_count, 3'd0);
      check("x0_ld_we3", we3, 1'b0);

      // Same-cycle re-issue and pop of r9: set wins
      chk_ad2 = 5'd9;
      @(negedge clk); ld_issue = 1'b1; ld_issue_rd = 5'd9;
      @(negedge clk); ld_issue = 1'b0;
      ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h99990001; expect_wr(5'd9, 32'h99990001);
      #1; check("r9_busy_a", busy2, 1'b1);
      @(negedge clk); ld_valid = 1'b0; ld_issue = 1'b1; ld_issue_rd = 5'd9;
      #1; check("r9_busy_b", busy2, 1'b1);
      @(negedge clk); ld_issue = 1'b0; #1;
      check("r9_we3", we3, 1'b1);
      @(negedge clk); #1;
      check("r9_we3_idle", we3, 1'b0);
      check("r9_busy_pending", busy2, 1'b1);
      ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h99990002; expect_wr(5'd9, 32'h99990002);
      @(negedge clk); ld_valid = 1'b0; #1;
      check("r9_busy_queued2", busy2, 1'b1);
      @(negedge clk); #1;
      check("r9_busy_inflight2", busy2, 1'b1);
      @(negedge clk); #1;
      check("r9_busy_clear", busy2, 1'b0);

      // Reset mid-stream with three queued loads and r5 pending
      chk_ad1 = 5'd5;
      @(negedge clk); ld_issue = 1'b1; ld_issue_rd = 5'd5;
      alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'hC0000000; expect_wr(5'd2, 32'hC0000000);
      ld_valid = 1'b1; ld_rd = 5'd5; ld_data = 32'hD0000000;
      @(negedge clk); ld_issue = 1'b0;
      alu_data = 32'hC0000001; expect_wr(5'd2, 32'hC0000001);
      ld_rd = 5'd6; ld_data = 32'hD0000001;
      @(negedge clk);
      alu_data = 32'hC0000002; expect_wr(5'd2, 32'hC0000002);
      ld_rd = 5'd8; ld_data = 32'hD0000002;
      @(negedge clk); alu_valid = 1'b0; ld_valid = 1'b0; #1;
      check("pre_rst_count", lq_count, 3'd3);
      check("pre_rst_busy", busy1, 1'b1);
      rst_n = 1'b0; #1;
      check("mid_rst_count", lq_count, 3'd0);
      check("mid_rst_ld_ready", ld_ready, 1'b1);
      check("mid_rst_busy", busy1, 1'b0);
      check("mid_rst_we3", we3, 1'b0);
      @(negedge clk); rst_n = 1'b1;
      repeat (3) @(negedge clk);
      #1; check("post_rst_we3", we3, 1'b0);
      check("sb_empty", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rf_wb_ctrl.md
Name: rf_wb_ctrl

Overview:
- Writer-side controller for the processor register file write port: drives we3/ad3/wd3.
- Merges single-cycle ALU results with out-of-order-latency load results, which are buffered in a small FIFO.
- Keeps a per-register pending scoreboard so decode can stall on operands whose load has not yet been written back.
- Sits between the execute/memory stages and the register file.

Parameters:
A_WIDTH, 5, register address width (2**A_WIDTH registers)
D_WIDTH, 32, data width
LQ_DEPTH, 4, load-result FIFO depth (power of two, >=2)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
alu_valid  in  1  ALU result present this cycle
alu_rd  in  A_WIDTH  ALU destination register
alu_data  in  D_WIDTH  ALU result
alu_stall  out  1  ALU result not taken; upstream must hold alu_* stable
ld_issue  in  1  load instruction issued this cycle
ld_issue_rd  in  A_WIDTH  destination of issued load
ld_valid  in  1  load data returned
ld_rd  in  A_WIDTH  load destination register
ld_data  in  D_WIDTH  load data
ld_ready  out  1  FIFO can accept (ld_valid && ld_ready = push)
chk_ad1  in  A_WIDTH  decode source operand 1
chk_ad2  in  A_WIDTH  decode source operand 2
busy1  out  1  chk_ad1 has a pending load
busy2  out  1  chk_ad2 has a pending load
we3  out  1  register file write enable (registered)
ad3  out  A_WIDTH  register file write address (registered)
wd3  out  D_WIDTH  register file write data (registered)
lq_count  out  $clog2(LQ_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async, rst_n=0): we3=0, ad3=0, wd3=0, FIFO empty (lq_count=0, ld_ready=1), all pending bits 0, busy1=busy2=0, alu_stall=0. Reset mid-operation discards all FIFO contents and pending bits immediately.
- FIFO:
  - Circular buffer, LQ_DEPTH entries of {rd, data}; pointers wrap modulo LQ_DEPTH.
  - ld_ready = !full.
  - A push while full is impossible by construction (the producer observes ld_ready).
  - A simultaneous push and pop when full is not allowed: ld_ready is already 0. When not full, count is unchanged.
- Arbitration, evaluated each cycle (select):
  - FIFO full and alu_valid: pop FIFO head; alu_stall=1.
  - Else alu_valid: take ALU; alu_stall=0.
  - Else FIFO non-empty: pop head.
  - Else idle.
  - alu_stall is combinational and equals (full && alu_valid).
- Write port:
  - Latency is one cycle: the selected result appears on we3/ad3/wd3 after the next rising edge.
  - The selected write goes out with we3=1 if rd!=0. A selected write to rd=0 gives we3=0 (x0 write discarded); ad3/wd3 then hold their previous values.
  - Idle cycle: we3=0.
- Scoreboard (pending[2**A_WIDTH]):
  - ld_issue with ld_issue_rd!=0 sets pending[ld_issue_rd].
  - Popping a load entry clears pending[entry.rd] at the same edge the write is registered.
  - Set and clear of the same register in the same cycle: set wins (a newer load is outstanding).
  - ALU writes never touch pending.
  - pending[0] is always 0.
- Busy outputs:
  - busy1 = pending[chk_ad1] || (FIFO holds an entry, or the current pop targets chk_ad1, not yet visible in the register file).
  - The actual rule: busy1 = pending[chk_ad1]. Since pending clears at the pop edge and wd3 lands in the register file one edge later, decode must also treat (we3 && ad3==chk_ad1) as busy for one cycle. This term is included in busy1/busy2.
  - busyN=0 whenever chk_adN=0.
- Only one load per destination may be outstanding. A second ld_issue to a pending register is legal; the bit simply stays set until the first pop. Ordering is the upstream's responsibility.

Decomposition:
- Package rf_wb_pkg holds:
  - typedef wb_entry_t {logic [A_WIDTH-1:0] rd; logic [D_WIDTH-1:0] data;}
  - localparam REG_COUNT = 2**A_WIDTH
  - enum wb_sel_t {SEL_IDLE, SEL_ALU, SEL_LQ}
- Sub-module wb_fifo: a generic synchronous FIFO (push/pop/full/empty/count, async active-low reset, clk/rst_n), instantiated once for the load queue.
- The scoreboard and arbiter stay in rf_wb_ctrl.

Test Plan:
- Reset with rst_n=0 mid-stream while FIFO holds 3 entries and pending[5]=1 -> immediately lq_count=0, ld_ready=1, busy for reg 5 = 0, we3=0.
- alu_valid=1, alu_rd=3, alu_data=32'hDEADBEEF for one cycle -> next edge: we3=1, ad3=3, wd3=32'hDEADBEEF; the following cycle we3=0.
- ld_issue rd=7; chk_ad1=7 -> busy1=1. Then ld_valid rd=7, data=32'h12345678 with no ALU traffic -> pop the next cycle; we3=1, ad3=7. busy1 stays 1 through the cycle after the write, then goes to 0.
- alu_valid held every cycle while 4 loads are pushed -> lq_count reaches 4, ld_ready=0, alu_stall=1. A load is written, the ALU result is held and written once no longer full, and no result is lost or duplicated.
- alu_valid rd=0 data=32'hFFFFFFFF, and a load to rd=0 -> we3 stays 0 for both. The load's pop still frees its FIFO slot.
- Same-cycle ld_issue rd=9 and pop of an older load rd=9 -> pending[9] remains 1 (busy for reg 9 = 1 until the second load's pop).
